// File: rtl/decode_queue_stage_pkg.sv
// rtl/decode_queue_stage_pkg.sv - shared types, opcode constants and decode helpers
package decode_queue_stage_pkg;

  localparam int DQ_XLEN = 64;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
    OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM, OP_ILLEGAL
  } decode_op_t;

  // EXT_NONE is zero so an unknown encoding leaves ctrl all-zero
  typedef enum logic [2:0] {EXT_NONE, EXT_I, EXT_S, EXT_B, EXT_U, EXT_J} ext_kind_t;

  typedef struct packed {
    ext_kind_t  ext;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_imm;
    logic       word;
    logic       alu_alt;
    logic [2:0] func3;
  } ctrl_t;

  typedef struct packed {
    logic [DQ_XLEN-1:0] pc;
    logic [31:0]        instr;
  } iq_entry_t;

  typedef struct packed {
    logic [DQ_XLEN-1:0] srca;
    logic [DQ_XLEN-1:0] srcb;
    logic [DQ_XLEN-1:0] ext_imm;
    logic [4:0]         dst;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    ctrl_t              ctrl;
    logic [1:0]         msize;
    logic               mem_unsigned;
    logic [DQ_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               valid;
  } decode_data_t;

  function automatic logic [DQ_XLEN-1:0] sign_ext(input logic [31:0] i, input ext_kind_t kind);
    case (kind)
      EXT_I:   sign_ext = {{(DQ_XLEN-12){i[31]}}, i[31:20]};
      EXT_S:   sign_ext = {{(DQ_XLEN-12){i[31]}}, i[31:25], i[11:7]};
      EXT_B:   sign_ext = {{(DQ_XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      EXT_U:   sign_ext = {{(DQ_XLEN-32){i[31]}}, i[31:12], 12'b0};
      EXT_J:   sign_ext = {{(DQ_XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: sign_ext = '0;
    endcase
  endfunction

  function automatic logic br_cmp(input logic [2:0] f3, input logic [DQ_XLEN-1:0] a,
                                  input logic [DQ_XLEN-1:0] b);
    case (f3)
      F3_BEQ:  br_cmp = (a == b);
      F3_BNE:  br_cmp = (a != b);
      F3_BLT:  br_cmp = ($signed(a) < $signed(b));
      F3_BGE:  br_cmp = ($signed(a) >= $signed(b));
      F3_BLTU: br_cmp = (a < b);
      F3_BGEU: br_cmp = (a >= b);
      default: br_cmp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue_stage_decode_logic.sv
// rtl/decode_queue_stage_decode_logic.sv - combinational instruction decoder and branch resolver
module decode_logic
  import decode_queue_stage_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [DQ_XLEN-1:0]  pc,
  input  logic [DQ_XLEN-1:0]  srca,
  input  logic [DQ_XLEN-1:0]  srcb,
  output logic [DQ_XLEN-1:0]  imm,
  output ext_kind_t           im_ext,
  output decode_op_t          op_t,
  output ctrl_t               ctrl,
  output logic [1:0]          msize,
  output logic                mem_unsigned,
  output logic                branch_taken,
  output logic [DQ_XLEN-1:0]  target
);

  always_comb begin
    op_t         = OP_ILLEGAL;
    ctrl         = '0;
    im_ext       = EXT_NONE;
    msize        = 2'b00;
    mem_unsigned = 1'b0;
    case (instr[6:0])
      OPC_LUI:    begin op_t = OP_LUI;   im_ext = EXT_U; ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1; end
      OPC_AUIPC:  begin op_t = OP_AUIPC; im_ext = EXT_U; ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1; end
      OPC_JAL:    begin op_t = OP_JAL;   im_ext = EXT_J; ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; end
      OPC_JALR: begin
        op_t = OP_JALR; im_ext = EXT_I;
        ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_imm = 1'b1;
      end
      OPC_BRANCH: begin op_t = OP_BRANCH; im_ext = EXT_B; ctrl.branch = 1'b1; end
      OPC_LOAD: begin
        op_t = OP_LOAD; im_ext = EXT_I;
        ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.alu_imm = 1'b1;
        msize = instr[13:12]; mem_unsigned = instr[14];
      end
      OPC_STORE: begin
        op_t = OP_STORE; im_ext = EXT_S;
        ctrl.mem_write = 1'b1; ctrl.alu_imm = 1'b1; msize = instr[13:12];
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        op_t = OP_ALUI; im_ext = EXT_I;
        ctrl.reg_write = 1'b1; ctrl.alu_imm = 1'b1;
        ctrl.word    = (instr[6:0] == OPC_OPIMM32);
        ctrl.alu_alt = instr[30] & (instr[14:12] == 3'b101);
      end
      OPC_OP, OPC_OP32: begin
        op_t = OP_ALU; ctrl.reg_write = 1'b1;
        ctrl.word    = (instr[6:0] == OPC_OP32);
        ctrl.alu_alt = (instr[31:25] == F7_ALT);
      end
      OPC_FENCE:  begin op_t = OP_FENCE;  im_ext = EXT_I; end
      OPC_SYSTEM: begin op_t = OP_SYSTEM; im_ext = EXT_I; end
      default: ;
    endcase
    if (op_t != OP_ILLEGAL) ctrl.func3 = instr[14:12];
  end

  assign imm          = sign_ext(instr, im_ext);
  assign branch_taken = ctrl.jump | (ctrl.branch & br_cmp(instr[14:12], srca, srcb));
  assign target       = (op_t == OP_JALR) ? ((srca + imm) & ~DQ_XLEN'(1)) : (pc + imm);

endmodule

// File: rtl/decode_queue_stage.sv
// rtl/decode_queue_stage.sv - instruction queue, decode output register and decode-stage redirect
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int XLEN         = DQ_XLEN,
  parameter int DEPTH        = 4,
  parameter bit BR_IN_DECODE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  input  logic [XLEN-1:0]  srca,
  input  logic [XLEN-1:0]  srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output decode_data_t     out_data,
  output decode_op_t       out_op,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             flush
);

  localparam int PW = $clog2(DEPTH);

  iq_entry_t           q [DEPTH];
  logic [PW-1:0]       head, tail;
  logic [PW:0]         count;
  iq_entry_t           head_e;
  logic                push, pop, take_redirect, redirect_q;

  logic [DQ_XLEN-1:0]  imm, target;
  ext_kind_t           im_ext;
  decode_op_t          op;
  ctrl_t               ctrl;
  logic [1:0]          msize;
  logic                mem_unsigned, branch_taken;
  decode_data_t        dec;

  assign head_e   = q[head];
  assign rs1      = head_e.instr[19:15];
  assign rs2      = head_e.instr[24:20];
  assign in_ready = (count < (PW+1)'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = (count != '0) & (~out_valid | out_ready);
  assign take_redirect = BR_IN_DECODE & pop & branch_taken;
  assign redirect_valid = BR_IN_DECODE & redirect_q;

  decode_logic u_decode (
    .instr        (head_e.instr),
    .pc           (head_e.pc),
    .srca         (srca),
    .srcb         (srcb),
    .imm          (imm),
    .im_ext       (im_ext),
    .op_t         (op),
    .ctrl         (ctrl),
    .msize        (msize),
    .mem_unsigned (mem_unsigned),
    .branch_taken (branch_taken),
    .target       (target)
  );

  always_comb begin
    dec              = '0;
    dec.srca         = (op == OP_AUIPC) ? head_e.pc : srca;
    dec.srcb         = (op == OP_JAL || op == OP_JALR) ? head_e.pc + 4 : srcb;
    dec.ext_imm      = imm;
    dec.dst          = head_e.instr[11:7];
    dec.rs1          = head_e.instr[19:15];
    dec.rs2          = head_e.instr[24:20];
    dec.ctrl         = ctrl;
    dec.ctrl.ext     = im_ext;
    dec.msize        = msize;
    dec.mem_unsigned = mem_unsigned;
    dec.pc           = head_e.pc;
    dec.instr        = head_e.instr;
    dec.valid        = 1'b1;
  end

  // flush shares the reset path so a stalled bundle and any queued entries vanish together
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_op      <= OP_NOP;
      redirect_q  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect_q <= take_redirect;
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= dec;
        out_op    <= op;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (take_redirect) begin
        redirect_pc <= target;
        head        <= head + 1'b1;
        tail        <= head + 1'b1;
        count       <= '0;
      end else begin
        if (pop) head <= head + 1'b1;
        if (push) begin
          q[tail] <= '{pc: in_pc, instr: in_instr};
          tail    <= tail + 1'b1;
        end
        count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
    end
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// tb/tb_decode_queue_stage.sv - directed bench with a queue-level reference model
module tb_decode_queue_stage;
  import decode_queue_stage_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [63:0] in_pc = '0, srca = '0, srcb = '0;
  logic [31:0] in_instr = '0;

  logic         ir [2], ov [2], rv [2];
  logic [4:0]   rs1_o [2], rs2_o [2];
  logic [63:0]  rp [2];
  decode_data_t od [2];
  decode_op_t   oo [2];

  int checks = 0, failures = 0;
  bit run_cmp = 1'b0;
  int wrap_seen = 0, wrap_pushed = 0;

  always #5 clk = ~clk;

  decode_queue_stage #(.XLEN(64), .DEPTH(4), .BR_IN_DECODE(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_pc(in_pc),
    .in_instr(in_instr), .rs1(rs1_o[0]), .rs2(rs2_o[0]), .srca(srca), .srcb(srcb),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_op(oo[0]),
    .redirect_valid(rv[0]), .redirect_pc(rp[0]), .flush(flush));

  decode_queue_stage #(.XLEN(64), .DEPTH(4), .BR_IN_DECODE(1'b0)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_pc(in_pc),
    .in_instr(in_instr), .rs1(rs1_o[1]), .rs2(rs2_o[1]), .srca(srca), .srcb(srcb),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_op(oo[1]),
    .redirect_valid(rv[1]), .redirect_pc(rp[1]), .flush(flush));

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // reference decoder written straight from the ISA encoding tables
  function automatic logic [63:0] m_imm(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h1b, 7'h03, 7'h67, 7'h0f, 7'h73: m_imm = {{52{i[31]}}, i[31:20]};
      7'h23: m_imm = {{52{i[31]}}, i[31:25], i[11:7]};
      7'h63: m_imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: m_imm = {{32{i[31]}}, i[31:12], 12'h000};
      7'h6f: m_imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: m_imm = 64'h0;
    endcase
  endfunction

  function automatic decode_op_t m_op(input logic [31:0] i);
    case (i[6:0])
      7'h37: m_op = OP_LUI;    7'h17: m_op = OP_AUIPC;
      7'h6f: m_op = OP_JAL;    7'h67: m_op = OP_JALR;
      7'h63: m_op = OP_BRANCH; 7'h03: m_op = OP_LOAD;
      7'h23: m_op = OP_STORE;  7'h13, 7'h1b: m_op = OP_ALUI;
      7'h33, 7'h3b: m_op = OP_ALU;
      7'h0f: m_op = OP_FENCE;  7'h73: m_op = OP_SYSTEM;
      default: m_op = OP_ILLEGAL;
    endcase
  endfunction

  function automatic bit m_redirect(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
    if (i[6:0] == 7'h6f || i[6:0] == 7'h67) return 1'b1;
    if (i[6:0] != 7'h63) return 1'b0;
    case (i[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [63:0] mpc [2][8];
  logic [31:0] mins [2][8];
  int          msz [2] = '{0, 0};
  bit          mov [2] = '{0, 0};
  bit          mrv [2] = '{0, 0};
  logic [63:0] mrpc [2], e_pc [2], e_imm [2], e_sa [2], e_sb [2];
  logic [31:0] e_ins [2];
  decode_op_t  e_op [2];

  always @(posedge clk) begin
    bit do_pop, do_push;
    logic [63:0] hp;
    logic [31:0] hi;
    for (int k = 0; k < 2; k++) begin
      if (reset || flush) begin
        msz[k] = 0; mov[k] = 0; mrv[k] = 0;
      end else begin
        do_push = in_valid && msz[k] < 4;
        do_pop  = msz[k] > 0 && (!mov[k] || out_ready);
        mrv[k]  = 0;
        if (do_pop) begin
          hp = mpc[k][0];
          hi = mins[k][0];
          for (int j = 0; j < 7; j++) begin
            mpc[k][j] = mpc[k][j+1];
            mins[k][j] = mins[k][j+1];
          end
          msz[k]--;
          mov[k]   = 1;
          e_pc[k]  = hp;
          e_ins[k] = hi;
          e_imm[k] = m_imm(hi);
          e_op[k]  = m_op(hi);
          e_sa[k]  = (hi[6:0] == 7'h17) ? hp : srca;
          e_sb[k]  = (hi[6:0] == 7'h6f || hi[6:0] == 7'h67) ? hp + 64'd4 : srcb;
          if (k == 0 && m_redirect(hi, srca, srcb)) begin
            mrv[k]  = 1;
            mrpc[k] = (hi[6:0] == 7'h67) ? ((srca + e_imm[k]) & ~64'd1) : hp + e_imm[k];
            msz[k]  = 0;
            do_push = 0;
          end
        end else if (out_ready) begin
          mov[k] = 0;
        end
        if (do_push) begin
          mpc[k][msz[k]]  = in_pc;
          mins[k][msz[k]] = in_instr;
          msz[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        check("in_ready", k, 64'(ir[k]), 64'(msz[k] < 4 && !flush));
        check("out_valid", k, 64'(ov[k]), 64'(mov[k]));
        check("redirect_valid", k, 64'(rv[k]), 64'(mrv[k]));
        if (mrv[k]) check("redirect_pc", k, rp[k], mrpc[k]);
        if (msz[k] > 0) check("rs1", k, 64'(rs1_o[k]), 64'(mins[k][0][19:15]));
        if (mov[k]) begin
          check("pc", k, od[k].pc, e_pc[k]);
          check("instr", k, 64'(od[k].instr), 64'(e_ins[k]));
          check("ext_imm", k, od[k].ext_imm, e_imm[k]);
          check("srca", k, od[k].srca, e_sa[k]);
          check("srcb", k, od[k].srcb, e_sb[k]);
          check("op", k, 64'(oo[k]), 64'(e_op[k]));
        end
      end
      if (in_valid && ir[0] && in_pc >= 64'h700 && in_pc < 64'h800) wrap_pushed++;
      if (ov[0] && out_ready && od[0].pc >= 64'h700 && od[0].pc < 64'h800) wrap_seen++;
    end
  end

  function automatic logic [31:0] addi(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  function automatic logic [31:0] btype(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] jalr_i, beq_i;

  initial begin
    jalr_i = {12'd4, 5'd5, 3'd0, 5'd1, 7'h67};
    beq_i  = btype(13'd16, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 0, 64'(ov[0]), 64'd0);
    check("rst_out_data_zero", 0, 64'(od[0] == '0), 64'd1);
    check("rst_out_op", 0, 64'(oo[0]), 64'(OP_NOP));
    check("rst_redirect_valid", 0, 64'(rv[0]), 64'd0);
    check("rst_redirect_pc", 0, rp[0], 64'd0);
    reset = 1'b0;
    run_cmp = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 64'h1000 + 64'(4*i), addi(12'(i+1)), 1'b1, 1'b0);
      if (i == 0) check("stream_lat0", 0, 64'(ov[0]), 64'd0);
      if (i == 1) begin
        check("stream_first_valid", 0, 64'(ov[0]), 64'd1);
        check("stream_first_pc", 0, od[0].pc, 64'h1000);
      end
      if (i == 2) check("stream_second_pc", 0, od[0].pc, 64'h1004);
    end
    drain(4);

    for (int i = 0; i < 6; i++) step(1'b1, 64'h2000 + 64'(4*i), addi(12'h7), 1'b0, 1'b0);
    check("fill_in_ready", 0, 64'(ir[0]), 64'd0);
    check("fill_out_pc", 0, od[0].pc, 64'h2000);
    step(1'b1, 64'h2018, addi(12'h7), 1'b1, 1'b0);
    check("fill_one_pop_ready", 0, 64'(ir[0]), 64'd1);
    check("fill_one_pop_pc", 0, od[0].pc, 64'h2004);
    step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    check("fill_stall_pc", 0, od[0].pc, 64'h2004);
    drain(6);

    for (int t = 0; t < 2; t++) begin
      srca = 64'd5; srcb = (t == 0) ? 64'd5 : 64'd6;
      step(1'b1, 64'h0f0, addi(12'h1), 1'b0, 1'b0);
      step(1'b1, 64'h100, beq_i, 1'b0, 1'b0);
      step(1'b1, 64'h104, addi(12'h2), 1'b0, 1'b0);
      step(1'b1, 64'h108, addi(12'h3), 1'b0, 1'b0);
      step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      check("beq_pop_pc", t, od[0].pc, 64'h100);
      check("beq_redirect", t, 64'(rv[0]), (t == 0) ? 64'd1 : 64'd0);
      if (t == 0) begin
        check("beq_redirect_pc", t, rp[0], 64'h110);
        check("beq_nodecode_redirect", t, 64'(rv[1]), 64'd0);
        step(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("beq_pulse_one_cycle", t, 64'(rv[0]), 64'd0);
        check("beq_held_pc", t, od[0].pc, 64'h100);
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("beq_younger_dropped", t, 64'(ov[0]), 64'd0);
      end else begin
        step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("bne_next_issues", t, od[0].pc, 64'h104);
      end
      drain(6);
    end

    srca = 64'h1001; srcb = 64'h0;
    step(1'b1, 64'h200, jalr_i, 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("jalr_redirect", 0, 64'(rv[0]), 64'd1);
    check("jalr_target", 0, rp[0], 64'h1004);
    check("jalr_link", 0, od[0].srcb, 64'h204);
    check("jalr_nodecode_redirect", 1, 64'(rv[1]), 64'd0);
    check("jalr_nodecode_valid", 1, 64'(ov[1]), 64'd1);
    check("jalr_nodecode_link", 1, od[1].srcb, 64'h204);
    drain(3);

    srca = '1; srcb = 64'd1;
    step(1'b1, 64'h300, btype(13'd8, 3'd4), 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("blt_taken", 0, 64'(rv[0]), 64'd1);
    check("blt_target", 0, rp[0], 64'h308);
    drain(2);
    step(1'b1, 64'h400, btype(13'd8, 3'd6), 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("bltu_not_taken", 0, 64'(rv[0]), 64'd0);
    check("bltu_valid", 0, 64'(ov[0]), 64'd1);
    drain(2);

    srca = '0; srcb = '0;
    for (int i = 0; i < 4; i++) step(1'b1, 64'h500 + 64'(4*i), addi(12'h9), 1'b0, 1'b0);
    step(1'b1, 64'h510, addi(12'h9), 1'b0, 1'b1);
    check("flush_out_valid", 0, 64'(ov[0]), 64'd0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("flush_no_push", 0, 64'(ov[0]), 64'd0);
    check("flush_empty_ready", 0, 64'(ir[0]), 64'd1);
    drain(2);

    step(1'b1, 64'h600, 32'h0000007f, 1'b1, 1'b0);
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("illegal_op", 0, 64'(oo[0]), 64'(OP_ILLEGAL));
    check("illegal_ctrl", 0, 64'(od[0].ctrl), 64'd0);
    drain(2);

    for (int i = 0; i < 12; i++) step(1'b1, 64'h700 + 64'(4*i), addi(12'(i)), (i % 4) != 0, 1'b0);
    drain(8);
    check("wrap_pushed", 0, 64'(wrap_pushed), 64'd12);
    check("wrap_seen", 0, 64'(wrap_seen), 64'd12);

    step(1'b1, 64'h800, addi(12'h1), 1'b0, 1'b0);
    step(1'b1, 64'h804, addi(12'h2), 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 64'h808, addi(12'h3), 1'b1, 1'b0);
    check("midrst_out_valid", 0, 64'(ov[0]), 64'd0);
    check("midrst_out_data", 0, 64'(od[0] == '0), 64'd1);
    check("midrst_out_op", 0, 64'(oo[0]), 64'(OP_NOP));
    reset = 1'b0;
    step(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    check("midrst_no_bundle", 0, 64'(ov[0]), 64'd0);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
